// File: rtl/crossbar_stream.sv
// crossbar_stream: NIN-input, NOUT-output streaming crossbar with one
// registered stage per output and all-or-nothing multicast.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_data/in_valid    NIN input streams, input i at [i*DW +: DW]
//   in_ready            per-input ready (combinational)
//   select              NOUT fields of SW bits; field j names the source of
//                       output j, codes >= NIN disable that output
//   out_data/out_valid  registered output streams, output j at [j*DW +: DW]
//   out_ready           per-output downstream ready
//   clr_err, err        sticky flag for select codes >= NIN other than all-ones
module crossbar_stream #(
   parameter int unsigned DW   = 8,
   parameter int unsigned NIN  = 3,
   parameter int unsigned NOUT = 3,
   parameter int unsigned SW   = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NIN*DW-1:0]  in_data,
   input  logic [NIN-1:0]     in_valid,
   output logic [NIN-1:0]     in_ready,
   input  logic [NOUT*SW-1:0] select,
   output logic [NOUT*DW-1:0] out_data,
   output logic [NOUT-1:0]    out_valid,
   input  logic [NOUT-1:0]    out_ready,
   input  logic               clr_err,
   output logic               err
);

   localparam logic [SW-1:0] NIN_C = SW'(NIN);
   localparam logic [SW-1:0] DIS_C = '1;

   logic [SW-1:0]      sel [NOUT];
   logic [NOUT-1:0]    en;
   logic [NOUT-1:0]    space;
   logic [NIN-1:0]     any_sel;
   logic [NIN-1:0]     blocked;
   logic [NIN-1:0]     fire;
   logic               err_set;

   logic [NOUT*DW-1:0] out_data_q,  out_data_d;
   logic [NOUT-1:0]    out_valid_q, out_valid_d;
   logic               err_q,       err_d;

   always_comb begin
      for (int unsigned j = 0; j < NOUT; j++) begin
         sel[j]   = select[j*SW +: SW];
         en[j]    = (sel[j] < NIN_C);
         space[j] = !out_valid_q[j] || out_ready[j];
      end
   end

   // An input is ready only if it has at least one enabled consumer and none
   // of its consumers is stalled, so a multicast beat lands everywhere at once.
   always_comb begin
      any_sel = '0;
      blocked = '0;
      for (int unsigned i = 0; i < NIN; i++) begin
         for (int unsigned j = 0; j < NOUT; j++) begin
            if (en[j] && (sel[j] == SW'(i))) begin
               any_sel[i] = 1'b1;
               if (!space[j]) blocked[i] = 1'b1;
            end
         end
      end
      in_ready = any_sel & ~blocked;
      fire     = in_valid & in_ready;
   end

   always_comb begin
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      err_set     = 1'b0;
      for (int unsigned j = 0; j < NOUT; j++) begin
         if (out_ready[j]) out_valid_d[j] = 1'b0;
         for (int unsigned i = 0; i < NIN; i++) begin
            if (en[j] && (sel[j] == SW'(i)) && fire[i]) begin
               out_valid_d[j]           = 1'b1;
               out_data_d[j*DW +: DW]   = in_data[i*DW +: DW];
            end
         end
         if (!en[j] && (sel[j] != DIS_C)) err_set = 1'b1;
      end
      if (err_set)      err_d = 1'b1;
      else if (clr_err) err_d = 1'b0;
      else              err_d = err_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_valid_q <= '0;
         err_q       <= 1'b0;
      end else begin
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         err_q       <= err_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign err       = err_q;

endmodule

// File: tb/tb_crossbar_stream.sv
// Bench for crossbar_stream with NIN=3, NOUT=3, SW=3 (all-ones code 7 is the
// silent disable, codes 3..6 are illegal).
module tb_crossbar_stream;

   localparam int unsigned DW   = 8;
   localparam int unsigned NIN  = 3;
   localparam int unsigned NOUT = 3;
   localparam int unsigned SW   = 3;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [NIN*DW-1:0]  in_data;
   logic [NIN-1:0]     in_valid;
   logic [NIN-1:0]     in_ready;
   logic [NOUT*SW-1:0] select;
   logic [NOUT*DW-1:0] out_data;
   logic [NOUT-1:0]    out_valid;
   logic [NOUT-1:0]    out_ready;
   logic               clr_err;
   logic               err;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 0;

   crossbar_stream #(.DW(DW), .NIN(NIN), .NOUT(NOUT), .SW(SW)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .select(select), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .clr_err(clr_err),
      .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Behavioural model: per output a "held beat" slot (valid flag + byte).
   bit       m_valid [NOUT];
   bit [7:0] m_data  [NOUT];
   bit       m_err;

   function automatic int src_of(int j);
      int s;
      s = int'(select[j*SW +: SW]);
      return (s < NIN) ? s : -1;
   endfunction

   // An input may go when someone wants it and every consumer can take it.
   function automatic logic [NIN-1:0] exp_ready();
      logic [NIN-1:0] r;
      for (int i = 0; i < NIN; i++) begin
         int  consumers;
         bit  all_free;
         consumers = 0;
         all_free  = 1;
         for (int j = 0; j < NOUT; j++)
            if (src_of(j) == i) begin
               consumers++;
               if (m_valid[j] && !out_ready[j]) all_free = 0;
            end
         r[i] = (consumers > 0) && all_free;
      end
      return r;
   endfunction

   function automatic logic [NOUT*DW-1:0] exp_data();
      logic [NOUT*DW-1:0] d;
      for (int j = 0; j < NOUT; j++) d[j*DW +: DW] = m_data[j];
      return d;
   endfunction

   function automatic logic [NOUT-1:0] exp_valid();
      logic [NOUT-1:0] v;
      for (int j = 0; j < NOUT; j++) v[j] = m_valid[j];
      return v;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < NOUT; j++) begin m_valid[j] = 0; m_data[j] = 0; end
         m_err = 0;
      end else begin
         logic [NIN-1:0] rdy;
         bit             bad;
         rdy = exp_ready();
         bad = 0;
         for (int j = 0; j < NOUT; j++) begin
            int s, code;
            s    = src_of(j);
            code = int'(select[j*SW +: SW]);
            if (code >= NIN && code != 7) bad = 1;
            if (s >= 0 && in_valid[s] && rdy[s]) begin
               m_valid[j] = 1;
               m_data[j]  = in_data[s*DW +: DW];
            end else if (out_ready[j]) begin
               m_valid[j] = 0;
            end
         end
         if (bad)          m_err = 1;
         else if (clr_err) m_err = 0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready", 32'(in_ready), 32'(exp_ready()));
         chk("out_valid", 32'(out_valid), 32'(exp_valid()));
         chk("out_data", 32'(out_data), 32'(exp_data()));
         chk("err", 32'(err), 32'(m_err));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [NOUT*SW-1:0] sels(input int s2, input int s1, input int s0);
      return {SW'(s2), SW'(s1), SW'(s0)};
   endfunction

   initial begin
      rst_n     = 1'b0;
      in_data   = '0;
      in_valid  = '0;
      select    = sels(7, 7, 7);
      out_ready = '0;
      clr_err   = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_data", 32'(out_data), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_in_ready", 32'(in_ready), 32'h0);
      #12;
      rst_n  = 1'b1;
      chk_en = 1;
      step();

      // Permutation: out2<-in0, out1<-in2, out0<-in1.
      select    = sels(0, 2, 1);
      in_data   = {8'h33, 8'h22, 8'h11};
      in_valid  = 3'b111;
      out_ready = 3'b111;
      step();
      chk("perm_data1", 32'(out_data), 32'h113322);
      chk("perm_valid1", 32'(out_valid), 32'h7);
      in_data = {8'h66, 8'h55, 8'h44};
      step();
      chk("perm_data2", 32'(out_data), 32'h446655);
      chk("perm_valid2", 32'(out_valid), 32'h7);

      // Multicast backpressure: out1 holds a beat, out_ready=101.
      in_valid = 3'b000;
      step();
      select   = sels(7, 1, 7);
      in_data  = {8'h00, 8'h3C, 8'h00};
      in_valid = 3'b010;
      out_ready = 3'b000;
      step();
      select    = sels(1, 1, 1);
      in_data   = {8'h00, 8'hA5, 8'h00};
      out_ready = 3'b101;
      #1;
      chk("mc_in_ready_blocked", 32'(in_ready), 32'h0);
      step();
      chk("mc_no_load_valid", 32'(out_valid), 32'h2);
      chk("mc_no_load_data", 32'(out_data[15:8]), 32'h3C);
      out_ready = 3'b111;
      #1;
      chk("mc_in_ready_open", 32'(in_ready), 32'h2);
      step();
      chk("mc_load_data", 32'(out_data), 32'hA5A5A5);
      chk("mc_load_valid", 32'(out_valid), 32'h7);

      // Disable with all-ones code while out0 holds 5A.
      select    = sels(7, 7, 0);
      in_data   = {8'h00, 8'h00, 8'h5A};
      in_valid  = 3'b001;
      out_ready = 3'b001;
      step();
      chk("dis_hold_data", 32'(out_data[7:0]), 32'h5A);
      select    = sels(7, 7, 7);
      in_valid  = 3'b111;
      step();
      chk("dis_valid", 32'(out_valid), 32'h6);
      chk("dis_data_held", 32'(out_data[7:0]), 32'h5A);
      chk("dis_err", 32'(err), 32'h0);
      step();
      chk("dis_no_reload", 32'(out_valid[0]), 32'h0);

      // Illegal select code 4.
      select    = sels(7, 7, 4);
      out_ready = 3'b111;
      step();
      chk("ill_err_set", 32'(err), 32'h1);
      chk("ill_disabled", 32'(out_valid), 32'h0);
      select  = sels(7, 7, 7);
      clr_err = 1'b1;
      step();
      chk("ill_err_clr", 32'(err), 32'h0);
      select = sels(7, 7, 4);
      step();
      chk("ill_set_wins", 32'(err), 32'h1);
      select  = sels(7, 7, 7);
      clr_err = 1'b0;
      step();
      chk("ill_sticky", 32'(err), 32'h1);
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;

      // Asynchronous reset between edges with all outputs full.
      select    = sels(0, 2, 1);
      in_data   = {8'h33, 8'h22, 8'h11};
      in_valid  = 3'b111;
      out_ready = 3'b111;
      step();
      chk("ar_full", 32'(out_valid), 32'h7);
      in_valid  = 3'b000;
      out_ready = 3'b000;
      #3;
      rst_n = 1'b0;
      #1;
      chk("ar_valid", 32'(out_valid), 32'h0);
      chk("ar_data", 32'(out_data), 32'h0);
      chk("ar_in_ready", 32'(in_ready), 32'h7);
      #2;
      rst_n     = 1'b1;
      in_data   = {8'h9C, 8'h8B, 8'h7A};
      in_valid  = 3'b111;
      out_ready = 3'b111;
      step();
      chk("ar_first_load", 32'(out_data), 32'h7A9C8B);
      chk("ar_first_valid", 32'(out_valid), 32'h7);

      // Random regression against the model.
      for (int n = 0; n < 2000; n++) begin
         in_data   = NIN*DW'($urandom);
         in_valid  = NIN'($urandom);
         out_ready = NOUT'($urandom);
         clr_err   = ($urandom_range(0, 7) == 0);
         for (int j = 0; j < NOUT; j++) begin
            int c;
            c = $urandom_range(0, 9);
            select[j*SW +: SW] = SW'((c > 7) ? c - 8 : c);
         end
         step();
      end

      chk_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/crossbar_stream.md
CROSSBAR_STREAM -- requirements
Module: crossbar_stream

Interface
REQ-001 Parameter DW, default 8, data width per port in bits.
REQ-002 Parameter NIN, default 3, number of input ports; legal range 2..8.
REQ-003 Parameter NOUT, default 3, number of output ports; legal range 1..8.
REQ-004 Parameter SW, default 2, select field width per output; SHALL satisfy 2^SW > NIN so one code is always "disabled".
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 in_data  input  NIN*DW  input i occupies bits [i*DW +: DW].
REQ-008 in_valid  input  NIN  per-input valid.
REQ-009 in_ready  output  NIN  per-input ready; combinational.
REQ-010 select  input  NOUT*SW  field j at [j*SW +: SW] names the source input for output j.
REQ-011 out_data  output  NOUT*DW  registered output data, output j at [j*DW +: DW].
REQ-012 out_valid  output  NOUT  registered per-output valid.
REQ-013 out_ready  input  NOUT  per-output downstream ready.
REQ-014 clr_err  input  1  synchronous clear of err.
REQ-015 err  output  1  sticky illegal-select flag.

Function
REQ-016 Output j is "enabled" when select field j < NIN; codes >= NIN mean disabled.
REQ-017 Output j has space when out_valid[j]=0 or out_ready[j]=1.
REQ-018 in_ready[i] SHALL be 1 only when at least one enabled output selects i and every enabled output selecting i has space; otherwise 0.
REQ-019 Input i fires when in_valid[i]=1 and in_ready[i]=1; multicast is all-or-nothing: every output selecting i loads the same beat in the same cycle.
REQ-020 On a fire of input i, each output j selecting i SHALL load out_data[j]=in_data[i] and set out_valid[j]=1 at the next edge (latency 1 cycle).
REQ-021 When out_valid[j]=1, out_ready[j]=1 and no new load: out_valid[j] clears; out_data[j] holds its last value.
REQ-022 Simultaneous drain and load on output j SHALL replace data with valid staying 1, sustaining one beat per cycle per output.
REQ-023 When out_valid[j]=1 and out_ready[j]=0, out_data[j] and out_valid[j] SHALL hold stable regardless of select or input changes.
REQ-024 Select is sampled every cycle; a select change affects only loads from that cycle on, never held data.
REQ-025 Inputs selected by no enabled output SHALL see in_ready=0 and are never dropped.
REQ-026 A disabled output SHALL drain any held beat normally and load nothing further.
REQ-027 err SHALL set at the edge after any cycle in which a select field is >= NIN and < 2^SW-1; the all-ones code is the intentional disable and does not set err.
REQ-028 clr_err=1 SHALL clear err at the next edge; if a set condition occurs in the same cycle, set wins.
REQ-029 Duplicate selects, where several outputs select one input, are legal multicast and SHALL not set err.

Reset
REQ-030 rst_n=0 SHALL immediately clear out_valid to 0, out_data to 0 and err to 0, independent of clk.
REQ-031 Reset asserted mid-transfer SHALL discard held beats; no stale out_valid after release.
REQ-032 After rst_n rises, the first load SHALL be possible at the first rising clk edge.

Verification
REQ-033 Permutation: select = out2<-0, out1<-2, out0<-1, all in_valid=1, all out_ready=1, in0/1/2 = 11/22/33 -> next cycle out0/1/2 = 22/33/11 with out_valid=111, and a new beat every cycle.
REQ-034 Multicast backpressure: all outputs select in1=A5, out_ready=101 with out1 already holding a beat -> in_ready[1]=0 and no output loads; raise out_ready[1] -> all three load A5 in one cycle.
REQ-035 Disable: select field 0 = 3 (all-ones) with out0 holding 5A and out_ready[0]=1 -> out_valid[0] clears next cycle, no reload, err stays 0.
REQ-036 Illegal select: NIN=3, SW=3, select field = 4 -> err=1 next cycle and that output disabled; clr_err with legal selects -> err=0; clr_err together with illegal select -> err stays 1.
REQ-037 Async reset: assert rst_n=0 between edges while out_valid=111 -> out_valid=000 and out_data=0 immediately, in_ready follows from the new space.
REQ-038 Random regression: random data, random selects, random valid/ready for 2000 cycles against a scoreboard -> no beat lost, duplicated or reordered per input/output pair.
